align_calc_pipe: RTL

ALIGN_CALC_PIPE -- requirements
Module: align_calc_pipe

---
 rtl/align_calc_pkg.sv | 50 +++++
 rtl/align_calc_pipe_operand_fifo.sv | 62 ++++++
 rtl/align_calc_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/align_calc_pkg.sv
`default_nettype none
// =============================================================================
// Module   : align_calc_pkg
// Brief    : Shared widths, stage records and the wrap/saturate helper for
//            align_calc_pipe. Supports DATA_WIDTH up to DW_MAX.
// Revision : 1.0 - initial release
// =============================================================================
package align_calc_pkg;

    localparam int DW_MAX = 32;
    localparam int W_FULL = 2 * DW_MAX + 5;

    typedef logic signed [W_FULL-1:0] full_t;

    typedef struct packed {
        full_t diff;
        full_t coef;
        full_t d4;
    } s1_rec_t;

    typedef struct packed {
        full_t acc;
    } s2_rec_t;

    typedef struct packed {
        logic [DW_MAX-1:0] q;
        logic              ovf;
    } clamp_t;

    // Range check against the signed dw-bit window; clamps only when sat_en.
    function automatic clamp_t wrap_sat(input full_t shifted, input int dw, input logic sat_en);
        full_t  hi;
        full_t  lo;
        clamp_t r;
        hi    = (full_t'(1) <<< (dw - 1)) - full_t'(1);
        lo    = ~hi;
        r.ovf = (shifted > hi) || (shifted < lo);
        r.q   = shifted[DW_MAX-1:0];
        if (sat_en) begin
            if (shifted > hi) begin
                r.q = hi[DW_MAX-1:0];
            end else if (shifted < lo) begin
                r.q = lo[DW_MAX-1:0];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/align_calc_pipe_operand_fifo.sv
`default_nettype none
// =============================================================================
// Module   : operand_fifo
// Brief    : Single-clock operand FIFO with registered read data; the read
//            register is the pipeline's pop stage.
// Revision : 1.0 - initial release
// =============================================================================
module operand_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  artsn_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic                  w_push;
    logic                  w_pop;

    // Extra MSB on each pointer separates full from empty when indices match.
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty_o = (r_wptr == r_rptr);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = r_rd_data;

    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= data_i;
        end
        if (w_pop) begin
            r_rd_data <= r_mem[r_rptr[AW-1:0]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/align_calc_pipe.sv
`default_nettype none
// =============================================================================
// Module   : align_calc_pipe
// Brief    : q = floor(((a-b)*(1+3c) - 4d) / 2) over four FIFO-buffered operand
//            streams, with wrap or saturate and a sticky range flag.
// Revision : 1.0 - initial release
// =============================================================================
module align_calc_pipe
    import align_calc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SAT_EN     = 0
) (
    input  logic                         clk_i,
    input  logic                         artsn_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic signed [DATA_WIDTH-1:0] c_i,
    input  logic signed [DATA_WIDTH-1:0] d_i,
    input  logic                         a_valid_i,
    input  logic                         b_valid_i,
    input  logic                         c_valid_i,
    input  logic                         d_valid_i,
    output logic                         a_ready_o,
    output logic                         b_ready_o,
    output logic                         c_ready_o,
    output logic                         d_ready_o,
    output logic signed [DATA_WIDTH-1:0] q_o,
    output logic                         q_valid_o,
    input  logic                         q_ready_i,
    output logic                         sat_o
);

    localparam int N_CH = 4;

    logic [N_CH-1:0][DATA_WIDTH-1:0] w_din;
    logic [N_CH-1:0][DATA_WIDTH-1:0] w_dout;
    logic [N_CH-1:0]                 w_push_req;
    logic [N_CH-1:0]                 w_full;
    logic [N_CH-1:0]                 w_empty;
    logic                            w_en;
    logic                            w_pop;
    full_t                           w_a;
    full_t                           w_b;
    full_t                           w_c;
    full_t                           w_d;
    s1_rec_t                         w_s1_next;
    clamp_t                          w_clamp;

    s1_rec_t                         r_s1;
    s2_rec_t                         r_s2;
    logic                            r_s0_valid;
    logic                            r_s1_valid;
    logic                            r_s2_valid;
    logic                            r_q_valid;
    logic signed [DATA_WIDTH-1:0]    r_q;
    logic                            r_sat;

    assign w_din      = {d_i, c_i, b_i, a_i};
    assign w_push_req = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};
    assign w_en       = !r_q_valid || q_ready_i;
    assign w_pop      = w_en && !(|w_empty);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_fifo
            operand_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .artsn_i (artsn_i),
                .push_i  (w_push_req[gi]),
                .data_i  (w_din[gi]),
                .pop_i   (w_pop),
                .data_o  (w_dout[gi]),
                .full_o  (w_full[gi]),
                .empty_o (w_empty[gi])
            );
        end
    endgenerate

    assign a_ready_o = !w_full[0];
    assign b_ready_o = !w_full[1];
    assign c_ready_o = !w_full[2];
    assign d_ready_o = !w_full[3];

    assign w_a = full_t'($signed(w_dout[0]));
    assign w_b = full_t'($signed(w_dout[1]));
    assign w_c = full_t'($signed(w_dout[2]));
    assign w_d = full_t'($signed(w_dout[3]));

    assign w_s1_next.diff = w_a - w_b;
    assign w_s1_next.coef = full_t'(1) + full_t'(3) * w_c;
    assign w_s1_next.d4   = w_d <<< 2;

    assign w_clamp = wrap_sat(r_s2.acc >>> 1, DATA_WIDTH, SAT_EN != 0);

    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_q_valid  <= 1'b0;
            r_q        <= '0;
            r_sat      <= 1'b0;
        end else if (w_en) begin
            r_s0_valid <= w_pop;
            r_s1_valid <= r_s0_valid;
            r_s2_valid <= r_s1_valid;
            r_q_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                r_q <= w_clamp.q[DATA_WIDTH-1:0];
                if (w_clamp.ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    // Full-precision datapath; no reset needed since valids qualify it.
    always_ff @(posedge clk_i) begin
        if (w_en) begin
            r_s1     <= w_s1_next;
            r_s2.acc <= r_s1.diff * r_s1.coef - r_s1.d4;
        end
    end

    assign q_o       = r_q;
    assign q_valid_o = r_q_valid;
    assign sat_o     = r_sat;

endmodule
`default_nettype wire
